cpu_clock_ctrl: RTL
===================

// Module: cpu_clock_ctrl
// PURPOSE
//  Consumes the 1 Hz square wave from the 12 MHz->1 Hz divider and produces the CPU clock enable.
//  Selects between stop, slow (1 Hz), single-step (debounced push button) and full-speed (every cycle).
//  Honours a CPU halt request and exposes state/pulse count for LEDs/7-seg.
//  Sits between the clock divider and the CPU core; everything runs on clock_in (12 MHz).
// PARAMETERS
//  DEBOUNCE_CYCLES  240000  cycles a synced button level must be stable to be accepted (20 ms @12 MHz)
//  DB_W             18      width of debounce counter; must hold DEBOUNCE_CYCLES
// PORTS
//  clock_in    in   1   12 MHz system clock
//  nReset      in   1   asynchronous reset, active low
//  slow_clk    in   1   1 Hz square wave from divider; treated as asynchronous
//  step_btn    in   1   raw push button, active high, bouncing
//  mode        in   2   raw switches: 00 STOP, 01 SLOW, 10 STEP, 11 FAST
//  halt_req    in   1   from CPU, level; rising edge requests halt
//  cpu_ce      out  1   CPU clock enable, registered
//  state_out   out  3   current FSM state encoding (below)
//  btn_db      out  1   debounced button level
//  pulse_cnt   out  16  number of cpu_ce=1 cycles issued
// BEHAVIOUR
//  Reset (nReset=0, async): all sync flops 0, debounce counter 0, btn_db=0, cpu_ce=0,
//   pulse_cnt=0, state=STOP (3'd0); outputs held while nReset=0.
//  Sync: slow_clk, step_btn, mode, halt_req each through 2 flops; edge detect on a 3rd flop.
//   slow_clk sampled 1 at edge k -> slow_tick valid cycle after edge k+2 -> cpu_ce=1 after edge k+3.
//  Debounce: if synced btn != btn_db, counter increments; at DEBOUNCE_CYCLES-1 btn_db<=synced,
//   counter<=0. Any cycle synced==btn_db clears counter. step_tick = btn_db rising edge (1 cycle).
//  States: STOP=0, SLOW=1, STEP=2, FAST=3, HALTED=4.
//  Transitions (evaluated every edge, priority top-down):
//   1. not HALTED and halt_req rising edge (synced) -> HALTED; cpu_ce=0 that edge, pending tick dropped.
//   2. HALTED and step_tick -> state decoded from synced mode; that press yields no cpu_ce.
//   3. HALTED otherwise -> stay; mode changes ignored.
//   4. otherwise state <= decode(synced mode); change takes effect next edge.
//  cpu_ce next value: SLOW: slow_tick; STEP: step_tick; FAST: 1; STOP/HALTED: 0.
//   Computed from the *current* state; on the edge state changes, cpu_ce uses old state
//   unless rule 1 fires (halt wins). cpu_ce is never high two cycles running except FAST.
//  Ticks that arrive in a state that does not use them are discarded, never queued.
//  pulse_cnt increments by 1 on each edge where cpu_ce==1; wraps 16'hFFFF -> 16'h0000.
//  Mid-operation reset aborts debounce, clears count, returns to STOP; no cpu_ce glitch.
// TESTING  (sim with DEBOUNCE_CYCLES=4)
//  Reset: hold nReset=0, toggle all inputs -> cpu_ce=0, state_out=0, pulse_cnt=0, btn_db=0.
//  SLOW: mode=01, slow_clk 0->1 at edge k -> exactly one cpu_ce=1 cycle after edge k+3; pulse_cnt=1.
//  STEP+bounce: mode=10, step_btn 1,0,1 for 1 cycle each then held 1 -> btn_db rises after 4 stable
//   cycles, exactly one cpu_ce pulse; release and re-press -> pulse_cnt=2.
//  FAST+halt: mode=11 for 10 cycles -> cpu_ce high continuously; halt_req 0->1 -> cpu_ce=0
//   from synced edge, state_out=4; button press -> state_out=3, no pulse on that press.
//  Wrap: force pulse_cnt to 16'hFFFE, FAST 3 cycles -> FFFF, 0000, 0001.
//  STOP/discard: mode=00, slow_clk and step_btn toggled -> cpu_ce stays 0; switch to 01 -> no stale pulse.

Source files
------------

// File: rtl/cpu_clock_ctrl.sv
// CPU clock-enable controller: stop / 1 Hz slow / debounced single-step / full-speed, with CPU halt.
// Latency: slow_clk or halt_req edge sampled at edge k acts on cpu_ce/state after edge k+3.
// No backpressure: ticks arriving in a state that does not use them are dropped, never queued.
module cpu_clock_ctrl #(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int DB_W            = 18
) (
  input  logic        clock_in,
  input  logic        nReset,
  input  logic        slow_clk,
  input  logic        step_btn,
  input  logic [1:0]  mode,
  input  logic        halt_req,
  output logic        cpu_ce,
  output logic [2:0]  state_out,
  output logic        btn_db,
  output logic [15:0] pulse_cnt
);

  typedef enum logic [2:0] {
    ST_STOP   = 3'd0,
    ST_SLOW   = 3'd1,
    ST_STEP   = 3'd2,
    ST_FAST   = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  // Synchroniser chains: [0],[1] are the metastability pair, [2] is the edge-detect history
  logic [2:0]      r_slow_s;
  logic [2:0]      r_halt_s;
  logic [1:0]      r_btn_s;
  logic [1:0]      r_mode_s1;
  logic [1:0]      r_mode_s2;
  logic            r_slow_tick;
  logic            r_halt_tick;

  logic [DB_W-1:0] r_db_cnt;
  logic            r_btn_db;
  logic            r_btn_db_q;

  state_t          r_state;
  logic            r_cpu_ce;
  logic [15:0]     r_pulse_cnt;

  logic            w_step_tick;
  state_t          w_mode_state;

  // Step tick fires for the single cycle after the debounced level rises
  assign w_step_tick  = r_btn_db & ~r_btn_db_q;
  // Mode switches map one-to-one onto the four run states
  assign w_mode_state = state_t'({1'b0, r_mode_s2});

  // Bring asynchronous inputs into clock_in domain and register their rising edges
  always_ff @(posedge clock_in or negedge nReset) begin
    if (!nReset) begin
      r_slow_s    <= '0;
      r_halt_s    <= '0;
      r_btn_s     <= '0;
      r_mode_s1   <= '0;
      r_mode_s2   <= '0;
      r_slow_tick <= 1'b0;
      r_halt_tick <= 1'b0;
    end else begin
      r_slow_s    <= {r_slow_s[1:0], slow_clk};
      r_halt_s    <= {r_halt_s[1:0], halt_req};
      r_btn_s     <= {r_btn_s[0], step_btn};
      r_mode_s1   <= mode;
      r_mode_s2   <= r_mode_s1;
      r_slow_tick <= r_slow_s[1] & ~r_slow_s[2];
      r_halt_tick <= r_halt_s[1] & ~r_halt_s[2];
    end
  end

  // Accept a new button level only after it has differed from the current one for DEBOUNCE_CYCLES edges
  always_ff @(posedge clock_in or negedge nReset) begin
    if (!nReset) begin
      r_db_cnt   <= '0;
      r_btn_db   <= 1'b0;
      r_btn_db_q <= 1'b0;
    end else begin
      r_btn_db_q <= r_btn_db;
      if (r_btn_s[1] != r_btn_db) begin
        if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          r_btn_db <= r_btn_s[1];
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  // Mode FSM with registered enable; halt wins over everything, enable follows the pre-edge state
  always_ff @(posedge clock_in or negedge nReset) begin
    if (!nReset) begin
      r_state     <= ST_STOP;
      r_cpu_ce    <= 1'b0;
      r_pulse_cnt <= '0;
    end else begin
      if (r_cpu_ce) begin
        r_pulse_cnt <= r_pulse_cnt + 16'd1;
      end
      if ((r_state != ST_HALTED) && r_halt_tick) begin
        r_state  <= ST_HALTED;
        r_cpu_ce <= 1'b0;
      end else if (r_state == ST_HALTED) begin
        // The releasing press is consumed here and never becomes an enable
        if (w_step_tick) begin
          r_state <= w_mode_state;
        end
        r_cpu_ce <= 1'b0;
      end else begin
        r_state <= w_mode_state;
        case (r_state)
          ST_SLOW: r_cpu_ce <= r_slow_tick;
          ST_STEP: r_cpu_ce <= w_step_tick;
          ST_FAST: r_cpu_ce <= 1'b1;
          default: r_cpu_ce <= 1'b0;
        endcase
      end
    end
  end

  assign cpu_ce    = r_cpu_ce;
  assign state_out = r_state;
  assign btn_db    = r_btn_db;
  assign pulse_cnt = r_pulse_cnt;

endmodule
